// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues word reads to ROM and queues returned words for decode.
// Optional same-cycle response bypass when the queue is empty: define IFU_BYPASS_EN.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_rvalid_i,
    input  logic [31:0] rom_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL_W  = CW'(DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_addr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   credits;
    logic [31:0]   target;
    logic          head_valid;
    logic          accept;
    logic          issue;
    logic          push;
    logic          pop;
    logic          bypass;

    // Outstanding reads reserve queue slots, so a response can always be pushed.
    assign credits    = {1'b0, count} + {1'b0, outstanding};
    assign issue      = !rst && !jump_en_i && (credits < DEPTH_W);
    assign target     = jump_addr_i & ~32'h3;
    assign head_valid = (count != '0);
    assign accept     = rom_rvalid_i && (drop_cnt == '0) && !jump_en_i;
    assign pop        = head_valid && !hold_i && !jump_en_i;

`ifdef IFU_BYPASS_EN
    assign bypass = accept && !head_valid;
    assign push   = accept && !(bypass && !hold_i);
`else
    assign bypass = 1'b0;
    assign push   = accept;
`endif

    assign rom_req_o    = issue;
    assign rom_addr_o   = pc;
    assign inst_valid_o = head_valid || bypass;
    assign inst_o       = head_valid ? q_inst[rd_ptr] : (bypass ? rom_rdata_i : NOP);
    assign inst_addr_o  = head_valid ? q_addr[rd_ptr] : (bypass ? resp_pc : 32'h0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (jump_en_i) begin
            // In-flight reads belong to the old path; a response landing now is dropped too.
            pc          <= target;
            resp_pc     <= target;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(rom_rvalid_i);
            drop_cnt    <= outstanding - CW'(rom_rvalid_i);
        end else begin
            if (issue) pc <= pc + 32'd4;
            outstanding <= outstanding + CW'(issue) - CW'(rom_rvalid_i);
            if (rom_rvalid_i && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            if (accept) resp_pc <= resp_pc + 32'd4;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_inst[wr_ptr] <= rom_rdata_i;
            q_addr[wr_ptr] <= resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && (count == FULL_W)));
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a variable-latency ROM model and an in-order scoreboard.
module tb_ifu_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_i = 1'b1;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_rvalid_i = 1'b0;
    logic [31:0] rom_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rom_entry_t;

    rom_entry_t  rom_q[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;

`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    ifu_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .hold_i       (hold_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: score consumption and record ROM traffic at negedge, then advance the ROM.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (!rst && inst_valid_o && !hold_i && !jump_en_i) begin
            chk("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("inst_addr", inst_addr_o, e);
                chk("inst_data", inst_o, ~e);
            end
        end
        if (rst) begin
            rom_q.delete();
        end else begin
            if (rom_rvalid_i && rom_q.size() != 0) void'(rom_q.pop_front());
            if (rom_req_o) rom_q.push_back('{addr: rom_addr_o, due: cyc + lat});
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rom_q.size() != 0 && rom_q[0].due <= cyc) begin
            rom_rvalid_i = 1'b1;
            rom_rdata_i  = ~rom_q[0].addr;
        end else begin
            rom_rvalid_i = 1'b0;
            rom_rdata_i  = '0;
        end
        #1;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        hold_i = 1'b0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        hold_i = 1'b1;
    endtask

    task automatic jump_to(input logic [31:0] a);
        jump_en_i   = 1'b1;
        jump_addr_i = a;
        #1;
        chk("req_in_jump", {31'b0, rom_req_o}, 32'd0);
        tick();
        jump_en_i = 1'b0;
        #1;
        chk("valid_after_jump", {31'b0, inst_valid_o}, 32'd0);
        chk("pc_after_jump", rom_addr_o, a & ~32'h3);
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_req", {31'b0, rom_req_o}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'h0000_0013);
        chk("rst_addr", inst_addr_o, 32'h0);

        // Latency-1 stream from RESET_PC
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        hold_i = 1'b0;
        rst    = 1'b0;
        #1;
        chk("first_req", {31'b0, rom_req_o}, 32'd1);
        chk("first_addr", rom_addr_o, 32'h0);
        tick();
        chk("fill_valid1", {31'b0, inst_valid_o}, {31'b0, BYP});
        tick();
        chk("fill_valid2", {31'b0, inst_valid_o}, 32'd1);
        chk("fill_addr2", inst_addr_o, BYP ? 32'h4 : 32'h0);
        drain(20);

        // Hold at 0x8: queue fills, requests stop, head frozen
        repeat (6) tick();
        chk("hold_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("hold_addr", inst_addr_o, 32'h8);
        chk("hold_inst", inst_o, ~32'h8);
        chk("hold_req", {31'b0, rom_req_o}, 32'd0);
        chk("hold_pc", rom_addr_o, 32'h10);
        repeat (3) tick();
        chk("hold_addr_late", inst_addr_o, 32'h8);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h8 + 32'(4 * i));
        hold_i = 1'b0;
        tick();
        chk("resume_req", {31'b0, rom_req_o}, 32'd1);
        chk("resume_addr", rom_addr_o, 32'h10);
        drain(30);

        // Jump together with hold on a full queue
        repeat (8) tick();
        chk("full_valid", {31'b0, inst_valid_o}, 32'd1);
        jump_to(32'h200);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        drain(30);

        // Latency 3, misaligned jump with two reads outstanding
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        lat = 3;
        repeat (2) tick();
        chk("lat3_credit_stall", {31'b0, rom_req_o}, 32'd0);
        jump_to(32'h103);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        drain(60);

        // Wrap through the top of the address space
        repeat (4) tick();
        jump_to(32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        drain(60);

        // Reset with reads in flight
        repeat (4) tick();
        jump_to(32'h40);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_req", {31'b0, rom_req_o}, 32'd0);
        chk("mid_rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("mid_rst_inst", inst_o, 32'h0000_0013);
        chk("mid_rst_addr", inst_addr_o, 32'h0);
        rst = 1'b0;
        #1;
        chk("restart_req", {31'b0, rom_req_o}, 32'd1);
        chk("restart_addr", rom_addr_o, 32'h0);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(4 * i));
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
